// File: rtl/hazard_scoreboard_unit.sv
// Hazard/forwarding unit for the 5-stage core with a long-latency (LL) pending scoreboard.
// Per-operand forward/hazard detection lives in hsu_operand; the top owns scoreboard, counters and watchdog.

module hsu_operand #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] id_rs_i,
  input  logic          id_use_i,
  input  logic          id_branch_i,
  input  logic [AW-1:0] ex_rs_i,
  input  logic [AW-1:0] ex_rd_i,
  input  logic          ex_regwrite_i,
  input  logic [AW-1:0] mem_rd_i,
  input  logic          mem_regwrite_i,
  input  logic          mem_load_i,
  input  logic [AW-1:0] wb_rd_i,
  input  logic          wb_regwrite_i,
  input  logic          ll_done_i,
  input  logic [AW-1:0] ll_rd_i,
  input  logic          pend_i,
  output logic [1:0]    fwd_ex_o,
  output logic [1:0]    fwd_id_o,
  output logic          ex_hit_o,
  output logic          mem_hit_o,
  output logic          raw_ll_o
);
  function automatic logic hit(input logic [AW-1:0] rd, input logic wr, input logic [AW-1:0] rs);
    return wr && (rd != '0) && (rd == rs);
  endfunction

  logic mem_x, wb_x, ll_x;
  logic ex_m, mem_m, wb_m, ll_m;

  assign mem_x = hit(mem_rd_i, mem_regwrite_i, ex_rs_i);
  assign wb_x  = hit(wb_rd_i, wb_regwrite_i, ex_rs_i);
  assign ll_x  = hit(ll_rd_i, ll_done_i, ex_rs_i);

  assign ex_m  = id_use_i & hit(ex_rd_i, ex_regwrite_i, id_rs_i);
  assign mem_m = id_use_i & hit(mem_rd_i, mem_regwrite_i, id_rs_i);
  assign wb_m  = id_use_i & hit(wb_rd_i, wb_regwrite_i, id_rs_i);
  assign ll_m  = id_use_i & hit(ll_rd_i, ll_done_i, id_rs_i);

  always_comb begin
    fwd_ex_o = 2'b00;
    if (mem_x)     fwd_ex_o = 2'b01;
    else if (wb_x) fwd_ex_o = 2'b10;
    else if (ll_x) fwd_ex_o = 2'b11;
  end

  // A load result in EX/MEM is not available yet for a branch resolved in ID.
  always_comb begin
    fwd_id_o = 2'b00;
    if (id_branch_i) begin
      if (mem_m && !mem_load_i) fwd_id_o = 2'b01;
      else if (wb_m)            fwd_id_o = 2'b10;
      else if (ll_m)            fwd_id_o = 2'b11;
    end else if (ll_m) begin
      fwd_id_o = 2'b11;
    end
  end

  assign ex_hit_o  = ex_m;
  assign mem_hit_o = mem_m;
  assign raw_ll_o  = id_use_i & pend_i & ~ll_m;
endmodule

module hazard_scoreboard_unit #(
  parameter int REGS    = 32,
  parameter int AW      = 5,
  parameter int MAX_LL  = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [AW-1:0]    id_rs1_i,
  input  logic [AW-1:0]    id_rs2_i,
  input  logic             id_use1_i,
  input  logic             id_use2_i,
  input  logic [AW-1:0]    id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_ll_i,
  input  logic             id_branch_i,
  input  logic             flush_i,
  input  logic [AW-1:0]    ex_rs1_i,
  input  logic [AW-1:0]    ex_rs2_i,
  input  logic [AW-1:0]    ex_rd_i,
  input  logic             ex_regwrite_i,
  input  logic             ex_load_i,
  input  logic [AW-1:0]    mem_rd_i,
  input  logic             mem_regwrite_i,
  input  logic             mem_load_i,
  input  logic [AW-1:0]    wb_rd_i,
  input  logic             wb_regwrite_i,
  input  logic             ll_done_i,
  input  logic [AW-1:0]    ll_rd_i,
  output logic [1:0]       fwd_ex1_o,
  output logic [1:0]       fwd_ex2_o,
  output logic [1:0]       fwd_id1_o,
  output logic [1:0]       fwd_id2_o,
  output logic             stall_o,
  output logic             bubble_o,
  output logic             ll_busy_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic             ll_timeout_o
);
  localparam int OW = $clog2(MAX_LL + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [REGS-1:0]  pend_q, pend_d;
  logic [OW-1:0]    outst_q, outst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic             to_q, to_d;

  logic [1:0][AW-1:0] id_rs, ex_rs;
  logic [1:0]         id_use, pend, ex_hit, mem_hit, raw_ll;
  logic [1:0][1:0]    fwd_ex, fwd_id;

  assign id_rs  = {id_rs2_i, id_rs1_i};
  assign ex_rs  = {ex_rs2_i, ex_rs1_i};
  assign id_use = {id_use2_i, id_use1_i};
  assign pend   = {pend_q[id_rs2_i], pend_q[id_rs1_i]};

  for (genvar g = 0; g < 2; g++) begin : g_op
    hsu_operand #(.AW(AW)) u_op (
      .id_rs_i       (id_rs[g]),
      .id_use_i      (id_use[g]),
      .id_branch_i   (id_branch_i),
      .ex_rs_i       (ex_rs[g]),
      .ex_rd_i       (ex_rd_i),
      .ex_regwrite_i (ex_regwrite_i),
      .mem_rd_i      (mem_rd_i),
      .mem_regwrite_i(mem_regwrite_i),
      .mem_load_i    (mem_load_i),
      .wb_rd_i       (wb_rd_i),
      .wb_regwrite_i (wb_regwrite_i),
      .ll_done_i     (ll_done_i),
      .ll_rd_i       (ll_rd_i),
      .pend_i        (pend[g]),
      .fwd_ex_o      (fwd_ex[g]),
      .fwd_id_o      (fwd_id[g]),
      .ex_hit_o      (ex_hit[g]),
      .mem_hit_o     (mem_hit[g]),
      .raw_ll_o      (raw_ll[g])
    );
  end

  // A completion only counts when it retires something actually in flight.
  logic ll_eff, ll_inc, act, load_use, br_alu, br_ld, struct_h, waw, llc, other, stall, issue;

  assign ll_eff   = ll_done_i & (outst_q != '0) & pend_q[ll_rd_i];
  assign act      = id_valid_i & ~flush_i;
  assign load_use = ex_load_i & |ex_hit;
  assign br_alu   = id_branch_i & |ex_hit;
  assign br_ld    = id_branch_i & mem_load_i & |mem_hit;
  assign struct_h = id_ll_i & (outst_q == OW'(MAX_LL)) & ~ll_eff;
  assign waw      = id_regwrite_i & pend_q[id_rd_i] & ~(ll_done_i & (ll_rd_i == id_rd_i));
  assign llc      = |raw_ll | waw;
  assign other    = load_use | br_alu | br_ld | struct_h;
  assign stall    = act & (other | llc);
  assign issue    = act & ~stall;
  assign ll_inc   = issue & id_ll_i & (id_rd_i != '0);

  always_comb begin
    pend_d = pend_q;
    if (ll_eff) pend_d[ll_rd_i] = 1'b0;
    if (ll_inc) pend_d[id_rd_i] = 1'b1;
    pend_d[0] = 1'b0;

    outst_d = outst_q;
    case ({ll_inc, ll_eff})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

    wd_d = '0;
    if (act && llc && !other) wd_d = (wd_q == WW'(TIMEOUT)) ? wd_q : wd_q + WW'(1);
    to_d = to_q | (wd_d == WW'(TIMEOUT));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q  <= '0;
      outst_q <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      outst_q <= outst_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  // Combinational outputs are held low while reset is asserted.
  assign fwd_ex1_o      = rst_i ? 2'b00 : fwd_ex[0];
  assign fwd_ex2_o      = rst_i ? 2'b00 : fwd_ex[1];
  assign fwd_id1_o      = rst_i ? 2'b00 : fwd_id[0];
  assign fwd_id2_o      = rst_i ? 2'b00 : fwd_id[1];
  assign stall_o        = ~rst_i & stall;
  assign bubble_o       = ~rst_i & (stall | flush_i);
  assign ll_busy_o      = (outst_q != '0);
  assign stall_cycles_o = cnt_q;
  assign ll_timeout_o   = to_q;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: combinational vector table plus scoreboard-driven sequences.
module tb_hazard_scoreboard_unit;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic id_valid, id_use1, id_use2, id_regwrite, id_ll, id_branch, flush;
  logic [AW-1:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, ll_rd;
  logic ex_regwrite, ex_load, mem_regwrite, mem_load, wb_regwrite, ll_done;
  logic [1:0] fwd_ex1, fwd_ex2, fwd_id1, fwd_id2;
  logic stall, bubble, ll_busy, ll_timeout;
  logic [CW-1:0] stall_cycles;

  hazard_scoreboard_unit #(.REGS(32), .AW(AW), .MAX_LL(4), .CNT_W(CW), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use1_i(id_use1), .id_use2_i(id_use2), .id_rd_i(id_rd),
    .id_regwrite_i(id_regwrite), .id_ll_i(id_ll), .id_branch_i(id_branch), .flush_i(flush),
    .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd),
    .ex_regwrite_i(ex_regwrite), .ex_load_i(ex_load),
    .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite), .mem_load_i(mem_load),
    .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite),
    .ll_done_i(ll_done), .ll_rd_i(ll_rd),
    .fwd_ex1_o(fwd_ex1), .fwd_ex2_o(fwd_ex2), .fwd_id1_o(fwd_id1), .fwd_id2_o(fwd_id2),
    .stall_o(stall), .bubble_o(bubble), .ll_busy_o(ll_busy),
    .stall_cycles_o(stall_cycles), .ll_timeout_o(ll_timeout)
  );

  typedef struct packed {
    logic vld; logic [AW-1:0] rs1, rs2; logic u1, u2; logic [AW-1:0] rd;
    logic rw, ll, br, fl;
    logic [AW-1:0] ers1, ers2, erd; logic erw, eld;
    logic [AW-1:0] mrd; logic mrw, mld;
    logic [AW-1:0] wrd; logic wrw;
    logic lld; logic [AW-1:0] llrd;
  } in_t;
  typedef struct packed { logic [1:0] fex1, fex2, fid1, fid2; logic st, bb; } exp_t;
  typedef struct { string name; in_t i; exp_t e; } vec_t;

  int n_pass = 0, n_total = 0, n_stall = 0;
  exp_t sb[$];
  string sb_name[$];
  vec_t tbl[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  function automatic in_t nop();
    in_t v;
    v = '0;
    return v;
  endfunction

  function automatic exp_t E(input logic [1:0] f1, f2, i1, i2, input logic s, b);
    exp_t e;
    e.fex1 = f1; e.fex2 = f2; e.fid1 = i1; e.fid2 = i2; e.st = s; e.bb = b;
    return e;
  endfunction

  function automatic in_t ll_op(input logic [AW-1:0] rd);
    in_t v;
    v = '0; v.vld = 1'b1; v.rd = rd; v.rw = 1'b1; v.ll = 1'b1;
    return v;
  endfunction

  function automatic in_t rd1(input logic [AW-1:0] rs);
    in_t v;
    v = '0; v.vld = 1'b1; v.rs1 = rs; v.u1 = 1'b1;
    return v;
  endfunction

  function automatic in_t done(input in_t b, input logic [AW-1:0] r);
    in_t v;
    v = b; v.lld = 1'b1; v.llrd = r;
    return v;
  endfunction

  task automatic add(input string n, input in_t i, input exp_t e);
    vec_t t;
    t.name = n; t.i = i; t.e = e;
    tbl.push_back(t);
  endtask

  task automatic drive(input in_t v);
    id_valid = v.vld; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use1 = v.u1; id_use2 = v.u2;
    id_rd = v.rd; id_regwrite = v.rw; id_ll = v.ll; id_branch = v.br; flush = v.fl;
    ex_rs1 = v.ers1; ex_rs2 = v.ers2; ex_rd = v.erd; ex_regwrite = v.erw; ex_load = v.eld;
    mem_rd = v.mrd; mem_regwrite = v.mrw; mem_load = v.mld;
    wb_rd = v.wrd; wb_regwrite = v.wrw; ll_done = v.lld; ll_rd = v.llrd;
  endtask

  task automatic compare_outputs();
    exp_t e;
    string n;
    e = sb.pop_front();
    n = sb_name.pop_front();
    chk({n, ".fwd_ex1"}, 32'(fwd_ex1), 32'(e.fex1));
    chk({n, ".fwd_ex2"}, 32'(fwd_ex2), 32'(e.fex2));
    chk({n, ".fwd_id1"}, 32'(fwd_id1), 32'(e.fid1));
    chk({n, ".fwd_id2"}, 32'(fwd_id2), 32'(e.fid2));
    chk({n, ".stall"},   32'(stall),   32'(e.st));
    chk({n, ".bubble"},  32'(bubble),  32'(e.bb));
  endtask

  // One cycle: drive after the edge, compare mid-cycle, then advance.
  task automatic step(input string n, input in_t v, input exp_t e);
    drive(v);
    sb.push_back(e);
    sb_name.push_back(n);
    @(negedge clk);
    compare_outputs();
    if (e.st) n_stall++;
    @(posedge clk); #1;
  endtask

  initial begin
    in_t v, w;
    int sat;

    v = nop(); add("idle", v, E(0, 0, 0, 0, 0, 0));
    v = nop(); v.vld = 1; v.ers1 = 9; v.mrd = 9; v.mrw = 1; v.wrd = 9; v.wrw = 1;
    add("exmem_over_wb", v, E(1, 0, 0, 0, 0, 0));
    v = nop(); v.vld = 1; v.ers1 = 9; v.ers2 = 9; v.wrd = 9; v.wrw = 1;
    add("wb_both", v, E(2, 2, 0, 0, 0, 0));
    v = nop(); v.vld = 1; v.mrw = 1; v.wrw = 1; v.erw = 1; v.br = 1; v.u1 = 1;
    add("x0_never", v, E(0, 0, 0, 0, 0, 0));
    v = nop(); v.vld = 1; v.ers1 = 4; v.mrd = 4; v.wrd = 4; v.wrw = 1;
    add("mem_norw", v, E(2, 0, 0, 0, 0, 0));
    v = rd1(5); v.rd = 8; v.rw = 1; v.erd = 5; v.erw = 1; v.eld = 1;
    add("loaduse_c1", v, E(0, 0, 0, 0, 1, 1));
    w = v; w.fl = 1; add("loaduse_flush", w, E(0, 0, 0, 0, 0, 1));
    w = v; w.vld = 0; add("loaduse_invalid", w, E(0, 0, 0, 0, 0, 0));
    w = v; w.u1 = 0; add("loaduse_nouse", w, E(0, 0, 0, 0, 0, 0));
    w = v; w.eld = 0; add("alu_in_ex", w, E(0, 0, 0, 0, 0, 0));
    v = rd1(5); v.rd = 8; v.rw = 1; v.mrd = 5; v.mrw = 1; v.mld = 1;
    add("loaduse_c2", v, E(0, 0, 0, 0, 0, 0));
    v = nop(); v.vld = 1; v.ers1 = 5; v.wrd = 5; v.wrw = 1;
    add("loaduse_c3", v, E(2, 0, 0, 0, 0, 0));
    v = nop(); v.vld = 1; v.br = 1; v.rs2 = 6; v.u2 = 1; v.erd = 6; v.erw = 1; v.eld = 1;
    add("br_load_c1", v, E(0, 0, 0, 0, 1, 1));
    v = nop(); v.vld = 1; v.br = 1; v.rs2 = 6; v.u2 = 1; v.mrd = 6; v.mrw = 1; v.mld = 1;
    add("br_load_c2", v, E(0, 0, 0, 0, 1, 1));
    v = nop(); v.vld = 1; v.br = 1; v.rs2 = 6; v.u2 = 1; v.wrd = 6; v.wrw = 1;
    add("br_load_c3", v, E(0, 0, 0, 2, 0, 0));
    v = nop(); v.vld = 1; v.br = 1; v.rs1 = 7; v.u1 = 1; v.erd = 7; v.erw = 1;
    add("br_alu_c1", v, E(0, 0, 0, 0, 1, 1));
    v = nop(); v.vld = 1; v.br = 1; v.rs1 = 7; v.u1 = 1; v.mrd = 7; v.mrw = 1;
    add("br_alu_c2", v, E(0, 0, 1, 0, 0, 0));
    w = v; w.br = 0; add("nonbr_mem", w, E(0, 0, 0, 0, 0, 0));

    drive(nop());
    rst = 1'b1;
    #3;
    chk("reset.stall", 32'(stall), 0);
    chk("reset.busy", 32'(ll_busy), 0);
    chk("reset.stall_cycles", 32'(stall_cycles), 0);
    chk("reset.timeout", 32'(ll_timeout), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[k]) step(tbl[k].name, tbl[k].i, tbl[k].e);

    // Long-latency RAW, then WAW.
    step("div_x7", ll_op(7), E(0, 0, 0, 0, 0, 0));
    chk("div_x7.busy", 32'(ll_busy), 1);
    v = rd1(7); v.rd = 8; v.rw = 1;
    for (int k = 0; k < 5; k++) step("raw_wait", v, E(0, 0, 0, 0, 1, 1));
    step("raw_done", done(v, 7), E(0, 0, 3, 0, 0, 0));
    chk("raw_done.busy", 32'(ll_busy), 0);
    step("ll_x10", ll_op(10), E(0, 0, 0, 0, 0, 0));
    v = nop(); v.vld = 1; v.rd = 10; v.rw = 1;
    step("waw_wait", v, E(0, 0, 0, 0, 1, 1));
    step("waw_done", done(v, 10), E(0, 0, 0, 0, 0, 0));
    chk("waw_done.busy", 32'(ll_busy), 0);

    // Structural limit.
    for (int r = 11; r <= 14; r++) step("fill", ll_op(AW'(r)), E(0, 0, 0, 0, 0, 0));
    step("ll5_full", ll_op(15), E(0, 0, 0, 0, 1, 1));
    step("ll5_done_same", done(ll_op(15), 11), E(0, 0, 0, 0, 0, 0));
    step("ll6_full", ll_op(16), E(0, 0, 0, 0, 1, 1));
    step("x11_cleared", rd1(11), E(0, 0, 0, 0, 0, 0));
    step("x15_pending", rd1(15), E(0, 0, 0, 0, 1, 1));
    for (int r = 12; r <= 14; r++) step("drain", done(nop(), AW'(r)), E(0, 0, 0, 0, 0, 0));
    chk("drain3.busy", 32'(ll_busy), 1);
    step("drain", done(nop(), 15), E(0, 0, 0, 0, 0, 0));
    chk("drain4.busy", 32'(ll_busy), 0);

    // Issue and completion on the same register: the new op stays pending.
    step("ll_x20", ll_op(20), E(0, 0, 0, 0, 0, 0));
    step("ll_x20_redo", done(ll_op(20), 20), E(0, 0, 0, 0, 0, 0));
    chk("set_wins.busy", 32'(ll_busy), 1);
    step("x20_pending", rd1(20), E(0, 0, 0, 0, 1, 1));
    step("x20_done", done(nop(), 20), E(0, 0, 0, 0, 0, 0));
    chk("x20_done.busy", 32'(ll_busy), 0);
    step("ll_x0", ll_op(0), E(0, 0, 0, 0, 0, 0));
    chk("ll_x0.busy", 32'(ll_busy), 0);
    step("done_idle", done(nop(), 5), E(0, 0, 0, 0, 0, 0));
    chk("no_underflow.busy", 32'(ll_busy), 0);
    sat = (n_stall > 15) ? 15 : n_stall;
    chk("stall_cycles", 32'(stall_cycles), 32'(sat));

    // Watchdog on a register that never completes, then async reset mid-stall.
    step("ll_x3", ll_op(3), E(0, 0, 0, 0, 0, 0));
    v = rd1(3); v.ers1 = 9; v.mrd = 9; v.mrw = 1;
    step("wd_c1", v, E(1, 0, 0, 0, 1, 1));
    repeat (62) @(posedge clk);
    @(negedge clk);
    chk("wd_63.timeout", 32'(ll_timeout), 0);
    chk("wd_63.stall", 32'(stall), 1);
    @(negedge clk);
    chk("wd_64.timeout", 32'(ll_timeout), 1);
    chk("wd_64.stall_cycles_sat", 32'(stall_cycles), 15);
    #2 rst = 1'b1;
    #1;
    chk("midrst.stall", 32'(stall), 0);
    chk("midrst.bubble", 32'(bubble), 0);
    chk("midrst.fwd_ex1", 32'(fwd_ex1), 0);
    chk("midrst.busy", 32'(ll_busy), 0);
    chk("midrst.stall_cycles", 32'(stall_cycles), 0);
    chk("midrst.timeout", 32'(ll_timeout), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    step("post_rst_x3", v, E(1, 0, 0, 0, 0, 0));
    step("stale_done", done(nop(), 3), E(0, 0, 0, 0, 0, 0));
    chk("stale_done.busy", 32'(ll_busy), 0);
    chk("stale_done.timeout", 32'(ll_timeout), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
